bcd_subtractor_serial: RTL and testbench
========================================

Name: bcd_subtractor_serial

Overview:
Digit-serial multi-digit BCD subtractor. It computes A - B - Bin, one BCD digit per clock, least-significant digit first, and is the inverse operation to the team's combinational BCD adder. It feeds the BCD arithmetic datapath alongside the adder and the multiplier, using a start/done handshake. Negative results are returned in ten's complement, with Bout set.

Parameters:
DIGITS, 4, number of BCD digits per operand (operand width = 4*DIGITS bits).

Ports:
clk    input   1          single clock, rising edge
rst    input   1          asynchronous, active-high reset
start  input   1          request; sampled only in IDLE
A      input   4*DIGITS   minuend, packed BCD, digit 0 in A[3:0]
B      input   4*DIGITS   subtrahend, packed BCD
Bin    input   1          borrow in
Diff   output  4*DIGITS   packed BCD result
Bout   output  1          borrow out (1 = result negative)
busy   output  1          high in every state except IDLE
done   output  1          one-cycle result-valid pulse
err    output  1          invalid-digit flag, valid with done

Behaviour:
- Reset (asynchronous, active-high):
  - state goes to IDLE immediately.
  - Diff=0, Bout=0, busy=0, done=0, err=0; internal registers cleared.
  - Reset mid-operation aborts the operation and drives the same values; no done pulse is produced.
- States: IDLE, CALC, FIN (plus NEG, only when the optional feature is compiled in).
- IDLE:
  - On an edge with start=1: latch A, B and Bin; set borrow register := Bin and digit counter := 0; go to CALC.
  - err_q := 1 if any nibble of A or B is greater than 9.
- CALC, one digit per edge, digit index i = counter:
  - t = A_i - B_i - borrow, computed signed, at least 6 bits wide.
  - If t < 0: digit = t + 10, borrow := 1. Otherwise: digit = t, borrow := 0.
  - The digit is written to result position i.
  - After digit DIGITS-1, go to FIN.
- FIN (exactly one cycle):
  - done=1.
  - Diff and Bout are updated from the result registers on entry to FIN and hold until the next completion or reset.
  - If err_q=1: Diff=0, Bout=0, err=1. Otherwise err=0.
  - Next edge goes to IDLE.
- Latency: done is high on the (DIGITS+1)th cycle after the start-sampling edge, i.e. cycle 5 for DIGITS=4. A start can be accepted again on the cycle after done.
- start while busy: ignored, no queuing; the operation in flight is unaffected.
- start held high continuously: a new operation begins on each return to IDLE.
- Wrap-around: 0 - 0 - 1 gives Diff = all 9s, Bout=1.
- A, B and Bin may change freely after the start-sampling edge.

Optional Feature:
- Macro: BCD_SUB_SIGNMAG_EN.
- Defined:
  - If the final borrow is 1 and err_q=0, go to NEG instead of FIN.
  - NEG runs DIGITS further cycles computing 0 - result using the same digit rule with initial borrow 0. This produces the magnitude |A - B - Bin|.
  - Bout stays 1 as the sign. Negative results complete in 2*DIGITS+1 cycles; positive results and errors are unchanged.
- Undefined:
  - The NEG state does not exist.
  - Negative results are presented in ten's complement in DIGITS+1 cycles.

Test Plan:
- A=0x1234, B=0x0234, Bin=0, start -> done on cycle 5; Diff=0x1000, Bout=0, err=0, busy high cycles 1-5.
- A=0x0003, B=0x0005, Bin=0 -> without macro: Diff=0x9998, Bout=1, done on cycle 5. With BCD_SUB_SIGNMAG_EN: Diff=0x0002, Bout=1, done on cycle 9.
- A=0x1000, B=0x0001, Bin=1 -> borrow ripples through three digits; Diff=0x0998, Bout=0. Also A=0, B=0, Bin=1 -> Diff=0x9999, Bout=1 (0x0001 with the macro).
- A=0x12A4, B=0x0001 -> done on cycle 5 with err=1, Diff=0x0000, Bout=0. Next operation, A=0x0009, B=0x0009 -> err=0, Diff=0x0000.
- Start an operation; pulse start with different operands on cycle 2 -> ignored, first result returned. Assert rst on cycle 3 -> all outputs 0 immediately, no done pulse. A fresh start then gives a correct result.
- start held high for 20 cycles with A=0x9999, B=0x1111 -> back-to-back done pulses every 6 cycles (5 busy cycles plus 1 IDLE), each with Diff=0x8888, Bout=0.

Source files
------------

// File: rtl/bcd_sub_if.sv
// bcd_sub_if: start/done handshake and operand/result bus for the serial BCD subtractor
interface bcd_sub_if #(parameter int DIGITS = 4);
  logic                start;
  logic [4*DIGITS-1:0] A;
  logic [4*DIGITS-1:0] B;
  logic                Bin;
  logic [4*DIGITS-1:0] Diff;
  logic                Bout;
  logic                busy;
  logic                done;
  logic                err;
  modport master (output start, A, B, Bin, input Diff, Bout, busy, done, err);
  modport slave (input start, A, B, Bin, output Diff, Bout, busy, done, err);
endinterface

// File: rtl/bcd_subtractor_serial.sv
// bcd_subtractor_serial: digit-serial BCD A - B - Bin, LSD first; BCD_SUB_SIGNMAG_EN selects sign-magnitude output
module bcd_subtractor_serial #(
  parameter int DIGITS = 4
) (
  input logic     clk,
  input logic     rst,
  bcd_sub_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = DIGITS > 1 ? $clog2(DIGITS) : 1;
`ifdef BCD_SUB_SIGNMAG_EN
  typedef enum logic [1:0] {IDLE, CALC, FIN, NEG} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
`endif
  state_t state, state_n;
  logic [W-1:0]  a_q, b_q, res_q, res_n, diff_q;
  logic [CW-1:0] cnt_q;
  logic          borrow_q, err_q, bout_q;
  logic [3:0]    m, s, dig;
  logic [5:0]    t;
  logic          neg, last, in_neg, to_neg;

  function automatic logic bad(input logic [W-1:0] v);
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) bad |= v[4*i +: 4] > 4'd9;
  endfunction

`ifdef BCD_SUB_SIGNMAG_EN
  assign in_neg = state == NEG;
  assign to_neg = state == CALC && state_n == NEG;
`else
  assign in_neg = 1'b0;
  assign to_neg = 1'b0;
`endif
  assign last     = cnt_q == CW'(DIGITS - 1);
  assign bus.Diff = diff_q;
  assign bus.Bout = bout_q;
  assign bus.busy = state != IDLE;
  assign bus.done = state == FIN;
  assign bus.err  = state == FIN && err_q;

  // one digit of minuend - subtrahend - borrow; NEG pass negates the stored result
  always_comb begin
    m     = in_neg ? 4'd0 : a_q[4*cnt_q +: 4];
    s     = in_neg ? res_q[4*cnt_q +: 4] : b_q[4*cnt_q +: 4];
    t     = {2'b00, m} - {2'b00, s} - {5'd0, borrow_q};
    neg   = t[5];
    dig   = neg ? t[3:0] + 4'd10 : t[3:0];
    res_n = res_q;
    res_n[4*cnt_q +: 4] = dig;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = bus.start ? CALC : IDLE;
`ifdef BCD_SUB_SIGNMAG_EN
      CALC: state_n = last ? ((neg && !err_q) ? NEG : FIN) : CALC;
      NEG:  state_n = last ? FIN : NEG;
`else
      CALC: state_n = last ? FIN : CALC;
`endif
      FIN:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // operand capture, digit iteration and result publication on entry to FIN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
      bout_q   <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        a_q      <= bus.A;
        b_q      <= bus.B;
        borrow_q <= bus.Bin;
        cnt_q    <= '0;
        res_q    <= '0;
        err_q    <= bad(bus.A) | bad(bus.B);
      end
      if (state == CALC || in_neg) begin
        res_q    <= res_n;
        cnt_q    <= last ? '0 : cnt_q + 1'b1;
        borrow_q <= to_neg ? 1'b0 : neg;
      end
      if (state_n == FIN && state != FIN) begin
        diff_q <= err_q ? '0 : res_n;
        bout_q <= !err_q && (neg || in_neg);
      end
    end
  end
endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// tb_bcd_subtractor_serial: directed and random checks of the serial BCD subtractor against a decimal model
module tb_bcd_subtractor_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  bcd_sub_if #(.DIGITS(4)) bus ();
  bcd_subtractor_serial #(.DIGITS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       output logic [15:0] d, output logic bo, output logic er, output int lat);
    int va = 0;
    int vb = 0;
    int v;
    er = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) er = 1'b1;
      va = va * 10 + int'(a[4*i +: 4]);
      vb = vb * 10 + int'(b[4*i +: 4]);
    end
    v   = va - vb - int'(bin);
    lat = 5;
    bo  = 1'b0;
    d   = '0;
    if (!er) begin
      if (v < 0) begin
        bo = 1'b1;
`ifdef BCD_SUB_SIGNMAG_EN
        d   = to_bcd(-v);
        lat = 9;
`else
        d = to_bcd(v + 10000);
`endif
      end else d = to_bcd(v);
    end
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.done) begin
        n = c;
        return;
      end
    end
  endtask

  task automatic kick(input logic [15:0] a, input logic [15:0] b, input logic bin);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.Bin   = bin;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = 16'($urandom);
    bus.B     = 16'($urandom);
    bus.Bin   = 1'($urandom);
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic bin, input string tag);
    logic [15:0] ed;
    logic        eb, ee;
    int          el, n;
    model(a, b, bin, ed, eb, ee, el);
    kick(a, b, bin);
    wait_done(n);
    check({tag, " lat"}, n, el);
    check({tag, " diff"}, bus.Diff, ed);
    check({tag, " bout"}, bus.Bout, eb);
    check({tag, " err"}, bus.err, ee);
    check({tag, " busy"}, bus.busy, 1);
    @(negedge clk);
    check({tag, " done_low"}, bus.done, 0);
    check({tag, " idle"}, bus.busy, 0);
    check({tag, " hold"}, bus.Diff, ed);
  endtask

  initial begin
    logic [15:0] a, b, ed;
    logic        eb, ee, seen;
    int          el, n, pulses, lastc;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Bin   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst diff", bus.Diff, 0);
    check("rst bout", bus.Bout, 0);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst err", bus.err, 0);
    rst = 1'b0;
    run(16'h1234, 16'h0234, 1'b0, "basic");
    run(16'h0003, 16'h0005, 1'b0, "neg");
    run(16'h1000, 16'h0001, 1'b1, "ripple");
    run(16'h0000, 16'h0000, 1'b1, "wrap");
    run(16'h12A4, 16'h0001, 1'b0, "invalid");
    run(16'h0009, 16'h0009, 1'b0, "after_err");
    run(16'h0000, 16'h9999, 1'b1, "min");
    // start pulsed while busy must not disturb the operation in flight
    model(16'h5678, 16'h1234, 1'b0, ed, eb, ee, el);
    kick(16'h5678, 16'h1234, 1'b0);
    @(negedge clk);
    bus.A     = 16'h1111;
    bus.B     = 16'h2222;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n);
    check("ignore lat", n + 2, el);
    check("ignore diff", bus.Diff, ed);
    @(negedge clk);
    // asynchronous reset mid-operation clears outputs at once and suppresses done
    kick(16'h9999, 16'h0000, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort diff", bus.Diff, 0);
    check("abort bout", bus.Bout, 0);
    check("abort busy", bus.busy, 0);
    check("abort done", bus.done, 0);
    check("abort err", bus.err, 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= bus.done;
    end
    check("abort no_done", seen, 0);
    run(16'h4321, 16'h1234, 1'b1, "fresh");
    // start held high: one completion every DIGITS+2 cycles
    @(negedge clk);
    bus.A     = 16'h9999;
    bus.B     = 16'h1111;
    bus.Bin   = 1'b0;
    bus.start = 1'b1;
    pulses = 0;
    lastc  = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.done) begin
        pulses++;
        check("b2b diff", bus.Diff, 16'h8888);
        check("b2b bout", bus.Bout, 0);
        if (lastc > 0) check("b2b gap", c - lastc, 6);
        lastc = c;
      end
    end
    bus.start = 1'b0;
    check("b2b pulses", pulses, 3);
    for (int c = 0; c < 20 && bus.busy; c++) @(negedge clk);
    check("b2b drain", bus.busy, 0);
    // random operands, occasionally with invalid nibbles
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 4; i++) begin
        a[4*i +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        b[4*i +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      run(a, b, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
